// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential handshake ALU: opcode encodings,
// FSM state encoding and a small opcode-classification helper.
package alu_seq_pkg;

  // Opcode encodings {s3,s2,s1,s0}. Shift opcodes ignore s1.
  localparam logic [3:0] OP_XFER = 4'b0000;  // Cin0: A, Cin1: A+1
  localparam logic [3:0] OP_ADD  = 4'b0001;  // A+B+Cin
  localparam logic [3:0] OP_SUB  = 4'b0010;  // A+~B+Cin
  localparam logic [3:0] OP_DEC  = 4'b0011;  // Cin0: A-1, Cin1: A
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;  // logical right
  localparam logic [3:0] OP_SAR  = 4'b1001;  // arithmetic right
  localparam logic [3:0] OP_SHL  = 4'b1100;  // left
  localparam logic [3:0] OP_MUL  = 4'b1101;  // multiply (left shift without multiplier)

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // True for the 11x1 opcode family that selects the multiplier.
  function automatic logic is_mul_op(input logic [3:0] op);
    return op[3] & op[2] & op[0];
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// start loads the operands; done pulses for one cycle once P is final.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_sum;

  // Conditionally add the multiplicand into the high half for this step.
  always_comb begin
    w_sum = {1'b0, r_hi};
    if (r_lo[0]) begin
      w_sum = {1'b0, r_hi} + {1'b0, r_mcand};
    end else begin
      w_sum = {1'b0, r_hi};
    end
  end

  // Load on start, then shift the partial product right one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_mcand <= A;
      r_hi    <= '0;
      r_lo    <= B;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      r_hi  <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = {r_hi, r_lo};

endmodule

// File: rtl/alu_seq_hs.sv
// Clocked opcode ALU with valid/ready handshakes on both sides, status flags
// and barrel shifts. Optional iterative multiplier: define ALU_SEQ_MUL_EN.
module alu_seq_hs
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Enter,
  input  logic             Reset,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_hi,
  output logic             Cout,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
);

  localparam int SHW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic               w_mul_fin;
  logic [2*WIDTH-1:0] w_p;

  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_beff;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shr_ext;
  logic [WIDTH:0]     w_sar_ext;
  logic [WIDTH:0]     w_shl_ext;
  logic [WIDTH-1:0]   w_f;
  logic               w_cout;
  logic               w_ovf;

  logic [WIDTH-1:0]   r_f;
  logic [WIDTH-1:0]   r_fhi;
  logic               r_cout;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;

  assign In_ready  = (r_state == IDLE) | ((r_state == DONE) & Out_ready);
  assign w_accept  = In_valid & In_ready;
  assign w_mul_fin = (r_state == BUSY) & w_mul_done & ~w_mul_busy;

`ifdef ALU_SEQ_MUL_EN
  assign w_is_mul = is_mul_op(S);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (Enter),
    .rst  (Reset),
    .start(w_accept & w_is_mul),
    .A    (A),
    .B    (B),
    .busy (w_mul_busy),
    .done (w_mul_done),
    .P    (w_p)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_p        = '0;
`endif

  // Second adder operand for the arithmetic group, chosen by s1:s0.
  always_comb begin
    w_beff = '0;
    case (S[1:0])
      2'b00:   w_beff = '0;
      2'b01:   w_beff = B;
      2'b10:   w_beff = ~B;
      2'b11:   w_beff = '1;
      default: w_beff = '0;
    endcase
  end

  // Adder and shifters; the extra LSB/MSB of each shift catches the last bit out.
  always_comb begin
    w_sh      = B[SHW-1:0];
    w_sum     = {1'b0, A} + {1'b0, w_beff} + {{WIDTH{1'b0}}, Cin};
    w_shr_ext = {A, 1'b0} >> w_sh;
    w_sar_ext = $unsigned($signed({A, 1'b0}) >>> w_sh);
    w_shl_ext = {1'b0, A} << w_sh;
  end

  // Opcode result mux with carry and signed-overflow generation.
  always_comb begin
    w_f    = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    casez (S)
      4'b00??: begin
        w_f    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (A[WIDTH-1] == w_beff[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  w_f = A & B;
      OP_OR:   w_f = A | B;
      OP_XOR:  w_f = A ^ B;
      OP_NOT:  w_f = ~A;
      4'b10?0: begin
        w_f    = w_shr_ext[WIDTH:1];
        w_cout = w_shr_ext[0];
      end
      4'b10?1: begin
        w_f    = w_sar_ext[WIDTH:1];
        w_cout = w_sar_ext[0];
      end
      4'b11??: begin
        // Multiply results bypass this mux; 11x1 is a left shift otherwise.
        w_f    = w_shl_ext[WIDTH-1:0];
        w_cout = w_shl_ext[WIDTH];
      end
      default: begin
        w_f    = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Enter) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: accept from IDLE, or from DONE while the result drains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? BUSY : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_fin) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      DONE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? BUSY : DONE;
        end else if (Out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result registers: capture at accept (or multiplier finish), hold otherwise.
  always_ff @(posedge Enter) begin
    if (Reset) begin
      r_f    <= '0;
      r_fhi  <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept & ~w_is_mul) begin
      r_f    <= w_f;
      r_fhi  <= '0;
      r_cout <= w_cout;
      r_zero <= (w_f == '0);
      r_neg  <= w_f[WIDTH-1];
      r_ovf  <= w_ovf;
    end else if (w_mul_fin) begin
      r_f    <= w_p[WIDTH-1:0];
      r_fhi  <= w_p[2*WIDTH-1:WIDTH];
      r_cout <= |w_p[2*WIDTH-1:WIDTH];
      r_zero <= (w_p[WIDTH-1:0] == '0);
      r_neg  <= w_p[WIDTH-1];
      r_ovf  <= 1'b0;
    end else begin
      r_f    <= r_f;
      r_fhi  <= r_fhi;
      r_cout <= r_cout;
      r_zero <= r_zero;
      r_neg  <= r_neg;
      r_ovf  <= r_ovf;
    end
  end

  assign Out_valid = (r_state == DONE);
  assign F         = r_f;
  assign F_hi      = r_fhi;
  assign Cout      = r_cout;
  assign Zero      = r_zero;
  assign Neg       = r_neg;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs (WIDTH=16): expected results are queued
// at accept time from a behavioural model and popped by an output monitor.
module tb_alu_seq_hs;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] f;
    logic [W-1:0] fhi;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
  } res_t;

  logic         Enter = 1'b0;
  logic         Reset;
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   S;
  logic         Cin;
  logic         Out_valid;
  logic         Out_ready;
  logic [W-1:0] F;
  logic [W-1:0] F_hi;
  logic         Cout;
  logic         Zero;
  logic         Neg;
  logic         Ovf;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;    // 0: always ready, 1: random, 2: never ready
  bit   mon_en = 1'b0;
  bit   hold_v = 1'b0;
  res_t held;
  res_t cur;

  alu_seq_hs #(.WIDTH(W)) dut (
    .Enter    (Enter),
    .Reset    (Reset),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .A        (A),
    .B        (B),
    .S        (S),
    .Cin      (Cin),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .F        (F),
    .F_hi     (F_hi),
    .Cout     (Cout),
    .Zero     (Zero),
    .Neg      (Neg),
    .Ovf      (Ovf)
  );

  always #5 Enter = ~Enter;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model straight from the opcode table, using wide integer math.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic c);
    res_t             r;
    logic [W-1:0]     beff;
    logic [W-1:0]     v;
    logic [2*W-1:0]   p;
    longint           u;
    longint           sv;
    longint           lim;
    int               n;
    r    = '0;
    beff = '0;
    lim  = longint'(1) << (W - 1);
    if (s[3:2] == 2'b00) begin
      case (s[1:0])
        2'b00:   beff = '0;
        2'b01:   beff = b;
        2'b10:   beff = ~b;
        default: beff = '1;
      endcase
      u      = longint'(a) + longint'(beff) + longint'(c);
      r.f    = u[W-1:0];
      r.cout = u[W];
      sv     = longint'($signed(a)) + longint'($signed(beff)) + longint'(c);
      r.ovf  = (sv >= lim) || (sv < -lim);
    end else if (s[3:2] == 2'b01) begin
      case (s[1:0])
        2'b00:   r.f = a & b;
        2'b01:   r.f = a | b;
        2'b10:   r.f = a ^ b;
        default: r.f = ~a;
      endcase
    end else begin
      n = int'(b) % W;
      v = a;
`ifdef ALU_SEQ_MUL_EN
      if (s[2] && s[0]) begin
        p      = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        v      = p[W-1:0];
        r.fhi  = p[2*W-1:W];
        r.cout = (r.fhi != '0);
        n      = 0;
      end
`endif
      if (!s[2]) begin
        repeat (n) begin
          r.cout = v[0];
          v = s[0] ? {v[W-1], v[W-1:1]} : {1'b0, v[W-1:1]};
        end
      end else if (!(s[2] && s[0]) || (r.fhi == '0 && !r.cout && n != 0) || 1'b1) begin
        repeat (n) begin
          r.cout = v[W-1];
          v = {v[W-2:0], 1'b0};
        end
      end
      r.f = v;
    end
    r.zero = (r.f == '0);
    r.neg  = r.f[W-1];
    return r;
  endfunction

  // Consumer side: Out_ready pattern changes just after each rising edge.
  initial begin
    Out_ready = 1'b1;
    forever begin
      @(posedge Enter);
      #1;
      case (rdy_mode)
        0:       Out_ready = 1'b1;
        1:       Out_ready = ($urandom_range(0, 3) != 0);
        default: Out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops and compares each delivered result; checks hold stability.
  initial begin
    forever begin
      @(negedge Enter);
      if (!mon_en) begin
        hold_v = 1'b0;
      end else begin
        cur = {F, F_hi, Cout, Zero, Neg, Ovf};
        if (hold_v) check("hold_stable", 64'(cur), 64'(held));
        if (Out_valid && Out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got F=%0h with no pending op", F);
          end else begin
            check("result", 64'(cur), 64'(exp_q.pop_front()));
          end
          hold_v = 1'b0;
        end else if (Out_valid) begin
          held   = cur;
          hold_v = 1'b1;
          check("in_ready_during_hold", 64'(In_ready), 64'd0);
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge Enter);
    #1;
    mon_en   = 1'b0;
    Reset    = 1'b1;
    In_valid = 1'b0;
    repeat (cycles) @(posedge Enter);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  // Present one operation and wait until it is accepted; queue its expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic c, output int waits);
    @(posedge Enter);
    #1;
    A = a; B = b; S = s; Cin = c; In_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge Enter);
      if (In_ready) begin
        exp_q.push_back(model(a, b, s, c));
        break;
      end
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: waited %0d cycles, required accept", waits);
        break;
      end
      @(posedge Enter);
      #1;
    end
  endtask

  task automatic idle();
    @(posedge Enter);
    #1;
    In_valid = 1'b0;
  endtask

  // Single op from idle: result must be valid one cycle after the accept edge.
  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic c, input logic [W-1:0] ef,
                          input logic [3:0] eflags);
    int w;
    issue(a, b, s, c, w);
    idle();
    @(negedge Enter);
    check({name, "_valid"}, 64'(Out_valid), 64'd1);
    check({name, "_F"}, 64'(F), 64'(ef));
    check({name, "_flags"}, 64'({Cout, Zero, Neg, Ovf}), 64'(eflags));
    check({name, "_Fhi"}, 64'(F_hi), 64'd0);
  endtask

  initial begin
    int w;
    int k;
    int bad;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    Reset = 1'b1; In_valid = 1'b0; A = '0; B = '0; S = 4'd0; Cin = 1'b0;
    do_reset(2);
    @(negedge Enter);
    check("rst_out_valid", 64'(Out_valid), 64'd0);
    check("rst_F", 64'(F), 64'd0);
    check("rst_Fhi", 64'(F_hi), 64'd0);
    check("rst_flags", 64'({Cout, Zero, Neg, Ovf}), 64'd0);
    check("rst_in_ready", 64'(In_ready), 64'd1);

    // flags order: {Cout, Zero, Neg, Ovf}
    directed("add_wrap", 16'hFFFF, 16'h0001, 4'b0001, 1'b0, 16'h0000, 4'b1100);
    directed("sub_ovf",  16'h8000, 16'h0001, 4'b0010, 1'b1, 16'h7FFF, 4'b1001);
    directed("sar4",     16'h8001, 16'h0004, 4'b1001, 1'b0, 16'hF800, 4'b0010);
    directed("shl1",     16'h8001, 16'h0001, 4'b1100, 1'b0, 16'h0002, 4'b1000);
    directed("shr0",     16'h8001, 16'h0000, 4'b1000, 1'b0, 16'h8001, 4'b0010);
    directed("inc_ovf",  16'h7FFF, 16'h1234, 4'b0000, 1'b1, 16'h8000, 4'b0011);
    directed("dec_zero", 16'h0000, 16'h0000, 4'b0011, 1'b0, 16'hFFFF, 4'b0010);
    directed("shr15",    16'h8000, 16'h000F, 4'b1010, 1'b0, 16'h0001, 4'b0000);

    // Backpressure: result held 3 cycles while a new op waits, then back-to-back.
    rdy_mode = 2;
    issue(16'h1234, 16'h0001, 4'b0001, 1'b0, w);
    @(posedge Enter);
    #1;
    A = 16'h00F0; B = 16'h0F0F; S = 4'b0100; Cin = 1'b0;
    repeat (3) begin
      @(negedge Enter);
      check("hold_in_ready", 64'(In_ready), 64'd0);
      check("hold_F", 64'(F), 64'h1235);
    end
    rdy_mode = 0;
    issue(16'h00F0, 16'h0F0F, 4'b0100, 1'b0, w);
    issue(16'hAAAA, 16'h5555, 4'b0110, 1'b1, w);
    check("back_to_back_waits", 64'(w), 64'd0);
    idle();
    repeat (3) @(negedge Enter);

`ifdef ALU_SEQ_MUL_EN
    issue(16'h0100, 16'h0100, 4'b1101, 1'b0, w);
    idle();
    k = 0;
    do begin
      @(negedge Enter);
      k++;
      if (k == 5) check("mul_busy_in_ready", 64'(In_ready), 64'd0);
    end while (!Out_valid && k < 40);
    check("mul_latency", 64'(k), 64'd17);
    check("mul_F", 64'(F), 64'h0000);
    check("mul_Fhi", 64'(F_hi), 64'h0001);
    check("mul_Cout", 64'(Cout), 64'd1);
    repeat (2) @(negedge Enter);

    issue(16'h0100, 16'h0100, 4'b1101, 1'b0, w);
    idle();
    repeat (4) @(posedge Enter);
    do_reset(1);
    bad = 0;
    repeat (20) begin
      @(negedge Enter);
      if (Out_valid) bad++;
    end
    check("mul_reset_no_valid", 64'(bad), 64'd0);
    check("mul_reset_Fhi", 64'(F_hi), 64'd0);
    check("mul_reset_in_ready", 64'(In_ready), 64'd1);
`endif

    // Randomised traffic with random consumer backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 16'h0000;
        1:       ra = 16'hFFFF;
        2:       ra = 16'h8000;
        3:       ra = 16'h7FFF;
        default: ra = W'($urandom);
      endcase
      rb = W'($urandom);
      issue(ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    rdy_mode = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge Enter);
      k++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge Enter);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
